ps2_key_tracker: RTL and testbench

- Parametrised successor to the keyboard keycode decoder.
- Consumes the PS/2 byte stream (keycode + oflag strobe) from the PS/2 receiver.
- Fully decodes make, break (F0) and extended (E0) sequences for a configurable key set.
- Outputs per key: held level, press pulse, release pulse, and an internally generated auto-repeat pulse for game control (W/A/D, space, enter).

---
 rtl/ps2_key_tracker_if.sv | 8 +
 rtl/ps2_key_tracker.sv | 192 +++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_tracker_if.sv
// PS/2 byte stream from the receiver: one byte on keycode per oflag strobe.
interface ps2_key_tracker_if;
  logic [7:0] keycode;
  logic       oflag;

  modport master (output keycode, output oflag);
  modport slave  (input  keycode, input  oflag);
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 key tracker: decodes make / break / E0-extended sequences for a
// configurable key set and produces held levels, press/release pulses,
// an auto-repeat pulse for the most recently pressed key and a sequence
// error pulse.
module ps2_key_tracker #(
  parameter int unsigned                NUM_KEYS       = 5,
  parameter logic [NUM_KEYS*8-1:0]      KEY_CODES      = {8'h5A, 8'h29, 8'h23, 8'h1C, 8'h1D},
  parameter logic [NUM_KEYS-1:0]        KEY_EXT        = '0,
  parameter int unsigned                REPEAT_DELAY   = 50_000_000,
  parameter int unsigned                REPEAT_PERIOD  = 10_000_000,
  parameter int unsigned                PREFIX_TIMEOUT = 2_000_000
) (
  input  logic                clk,
  input  logic                rst,
  ps2_key_tracker_if.slave    ps2,
  output logic [NUM_KEYS-1:0] key_held_o,
  output logic [NUM_KEYS-1:0] key_press_o,
  output logic [NUM_KEYS-1:0] key_release_o,
  output logic [NUM_KEYS-1:0] key_repeat_o,
  output logic                any_held_o,
  output logic                seq_error_o
);

  localparam int unsigned RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W    = $clog2(RPT_MAX + 1);
  localparam int unsigned TMO_W    = $clog2(PREFIX_TIMEOUT + 1);
  localparam int unsigned IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PREFIX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_DELAY  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] CNT_PERIOD = CNT_W'(REPEAT_PERIOD);
  localparam bit RPT_EN = (REPEAT_DELAY > 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ridx_q, ridx_d;
  logic               rvld_q, rvld_d;
  logic [NUM_KEYS-1:0] held_d, press_d, rel_d, rpt_d;

  logic               make_s, brk_s, ext_s, err_s;
  logic               hit_s;
  logic [IDX_W-1:0]   idx_s;

  // Prefix decoder: next state, completed make/break events and timeout errors.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    make_s  = 1'b0;
    brk_s   = 1'b0;
    ext_s   = 1'b0;
    err_s   = 1'b0;
    if (ps2.oflag) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (ps2.keycode == 8'hE0)      state_d = ST_EXT;
          else if (ps2.keycode == 8'hF0) state_d = ST_BRK;
          else                           make_s  = 1'b1;
        end
        ST_EXT: begin
          ext_s = 1'b1;
          if (ps2.keycode == 8'hF0)      state_d = ST_EXT_BRK;
          else if (ps2.keycode == 8'hE0) state_d = ST_EXT;
          else begin
            make_s  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (ps2.keycode == 8'hE0 || ps2.keycode == 8'hF0) err_s = 1'b1;
          else                                               brk_s = 1'b1;
        end
        ST_EXT_BRK: begin
          ext_s   = 1'b1;
          state_d = ST_IDLE;
          if (ps2.keycode == 8'hE0 || ps2.keycode == 8'hF0) err_s = 1'b1;
          else                                               brk_s = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // Waiting mid-sequence: give up after PREFIX_TIMEOUT silent cycles.
      if (tmo_q == TMO_LAST) begin
        err_s   = 1'b1;
        state_d = ST_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  // Key lookup: scan from the top so the lowest matching index wins.
  always_comb begin
    hit_s = 1'b0;
    idx_s = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (ps2.keycode == KEY_CODES[i*8 +: 8] && ext_s == KEY_EXT[i]) begin
        hit_s = 1'b1;
        idx_s = IDX_W'(i);
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Key state, pulses and auto-repeat bookkeeping for the coming cycle.
  always_comb begin
    held_d  = key_held_o;
    press_d = '0;
    rel_d   = '0;
    rpt_d   = '0;
    cnt_d   = cnt_q;
    ridx_d  = ridx_q;
    rvld_d  = rvld_q;
    if (RPT_EN && rvld_q && key_held_o[ridx_q]) begin
      if (cnt_q <= CNT_W'(1)) begin
        rpt_d[ridx_q] = 1'b1;
        cnt_d         = CNT_PERIOD;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
    // A fresh press takes over the repeat slot and cancels a coinciding expiry.
    if (make_s && hit_s && !key_held_o[idx_s]) begin
      held_d[idx_s]  = 1'b1;
      press_d[idx_s] = 1'b1;
      ridx_d         = idx_s;
      rvld_d         = 1'b1;
      cnt_d          = CNT_DELAY;
      rpt_d          = '0;
    end else begin
      ridx_d = ridx_d;
    end
    // Releasing the repeat key stops repetition, including a coinciding expiry.
    if (brk_s && hit_s && key_held_o[idx_s]) begin
      held_d[idx_s] = 1'b0;
      rel_d[idx_s]  = 1'b1;
      if (rvld_q && ridx_q == idx_s) begin
        rvld_d = 1'b0;
        cnt_d  = '0;
        rpt_d  = '0;
      end else begin
        rvld_d = rvld_d;
      end
    end else begin
      rvld_d = rvld_d;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tmo_q         <= '0;
      cnt_q         <= '0;
      ridx_q        <= '0;
      rvld_q        <= 1'b0;
      key_held_o    <= '0;
      key_press_o   <= '0;
      key_release_o <= '0;
      key_repeat_o  <= '0;
      any_held_o    <= 1'b0;
      seq_error_o   <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      cnt_q         <= cnt_d;
      ridx_q        <= ridx_d;
      rvld_q        <= rvld_d;
      key_held_o    <= held_d;
      key_press_o   <= press_d;
      key_release_o <= rel_d;
      key_repeat_o  <= rpt_d;
      any_held_o    <= |held_d;
      seq_error_o   <= err_s;
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: stimulus pushes expected output
// events (with the cycle they must appear in); a monitor pops and compares
// whenever the DUT shows any pulse.
module tb_ps2_key_tracker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_key_tracker_if bus ();

  logic [4:0] held, press, rel, rpt;
  logic       any, err;

  ps2_key_tracker #(
    .NUM_KEYS      (5),
    .KEY_CODES     (40'h5A_29_23_6B_1D),
    .KEY_EXT       (5'b00010),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (4),
    .PREFIX_TIMEOUT(20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2          (bus),
    .key_held_o   (held),
    .key_press_o  (press),
    .key_release_o(rel),
    .key_repeat_o (rpt),
    .any_held_o   (any),
    .seq_error_o  (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [4:0] pr;
    logic [4:0] rl;
    logic [4:0] rp;
    logic [4:0] hd;
    logic       er;
  } ev_t;

  ev_t expq[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  last_cap = 0;
  int  p_cyc, q_cyc, c_cyc;

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    bus.keycode = b;
    bus.oflag   = 1'b1;
    @(posedge clk); #1;
    bus.oflag   = 1'b0;
    last_cap    = cyc;
  endtask

  task automatic expect_ev(input int at, input logic [4:0] pr, input logic [4:0] rl,
                           input logic [4:0] rp, input logic [4:0] hd, input logic er);
    ev_t e;
    e.at = at; e.pr = pr; e.rl = rl; e.rp = rp; e.hd = hd; e.er = er;
    expq.push_back(e);
  endtask

  task automatic wait_to(input int x);
    while (cyc < x) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_lvl(input string nm, input logic [4:0] exp_held);
    n_chk++;
    if (held !== exp_held || any !== (|exp_held)) begin
      n_fail++;
      $display("FAIL %s: held=%b any=%b, expected held=%b any=%b", nm, held, any, exp_held, |exp_held);
    end
  endtask

  task automatic check_zero(input string nm);
    n_chk++;
    if (held !== 5'd0 || press !== 5'd0 || rel !== 5'd0 || rpt !== 5'd0 || any !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: held=%b press=%b release=%b repeat=%b any=%b err=%b, expected all zero",
               nm, held, press, rel, rpt, any, err);
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.keycode = 8'h00;
    bus.oflag   = 1'b0;

    // Monitor: every cycle showing a pulse must match the head of the queue.
    fork
      forever begin
        @(negedge clk);
        if (!rst && (|press || |rel || |rpt || err)) begin
          n_chk++;
          if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: cyc=%0d press=%b release=%b repeat=%b err=%b held=%b, expected no event",
                     cyc, press, rel, rpt, err, held);
          end else begin
            ev_t e;
            e = expq.pop_front();
            if (e.at != cyc || press !== e.pr || rel !== e.rl || rpt !== e.rp ||
                err !== e.er || held !== e.hd || any !== (|e.hd)) begin
              n_fail++;
              $display("FAIL event: got cyc=%0d press=%b release=%b repeat=%b err=%b held=%b any=%b, expected cyc=%0d press=%b release=%b repeat=%b err=%b held=%b",
                       cyc, press, rel, rpt, err, held, any, e.at, e.pr, e.rl, e.rp, e.er, e.hd);
            end
          end
        end
      end
    join_none

    // Reset state.
    #1;
    check_zero("reset_async");
    idle(3);
    check_zero("reset_held");
    rst = 1'b0;

    // Reset in the middle of a break sequence discards it.
    send(8'hF0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.keycode = 8'h1D;
    bus.oflag   = 1'b1;
    @(posedge clk); #1;
    bus.oflag   = 1'b0;
    check_zero("reset_mid_seq");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    check_zero("after_reset");
    // FSM is back in IDLE, so 1D is a make rather than the tail of a break.
    send(8'h1D);
    expect_ev(last_cap, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 1'b0);
    send(8'hF0); send(8'h1D);
    expect_ev(last_cap, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 1'b0);
    idle(4);

    // Make / break W.
    send(8'h1D);
    expect_ev(last_cap, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 1'b0);
    idle(1);
    check_lvl("w_held", 5'b00001);
    send(8'hF0); send(8'h1D);
    expect_ev(last_cap, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 1'b0);
    idle(2);
    check_lvl("w_released", 5'b00000);

    // Typematic repeats and an unknown code; break lands on the repeat expiry.
    send(8'h1D);
    c_cyc = last_cap;
    expect_ev(c_cyc, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 1'b0);
    send(8'h1D); send(8'h1D); send(8'h15);
    check_lvl("typematic_held", 5'b00001);
    send(8'hF0); send(8'h1D);
    expect_ev(last_cap, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 1'b0);
    idle(14);

    // Extended key: plain 6B is ignored, E0 6B is key 1.
    send(8'h6B);
    idle(2);
    check_lvl("ext_plain_ignored", 5'b00000);
    send(8'hE0); send(8'h6B);
    expect_ev(last_cap, 5'b00010, 5'b00000, 5'b00000, 5'b00010, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h6B);
    expect_ev(last_cap, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 1'b0);
    idle(4);

    // Auto-repeat on D, handover to space on the expiry cycle, stop on break.
    send(8'h23);
    p_cyc = last_cap;
    expect_ev(p_cyc,      5'b00100, 5'b00000, 5'b00000, 5'b00100, 1'b0);
    expect_ev(p_cyc + 10, 5'b00000, 5'b00000, 5'b00100, 5'b00100, 1'b0);
    expect_ev(p_cyc + 14, 5'b00000, 5'b00000, 5'b00100, 5'b00100, 1'b0);
    expect_ev(p_cyc + 18, 5'b00000, 5'b00000, 5'b00100, 5'b00100, 1'b0);
    wait_to(p_cyc + 20);
    send(8'h29);
    q_cyc = last_cap;
    expect_ev(q_cyc,      5'b01000, 5'b00000, 5'b00000, 5'b01100, 1'b0);
    expect_ev(q_cyc + 10, 5'b00000, 5'b00000, 5'b01000, 5'b01100, 1'b0);
    expect_ev(q_cyc + 14, 5'b00000, 5'b00000, 5'b01000, 5'b01100, 1'b0);
    wait_to(q_cyc + 14);
    send(8'hF0); send(8'h29);
    expect_ev(last_cap, 5'b00000, 5'b01000, 5'b00000, 5'b00100, 1'b0);
    idle(16);
    check_lvl("d_still_held", 5'b00100);
    send(8'hF0); send(8'h23);
    expect_ev(last_cap, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 1'b0);
    idle(4);

    // Prefix timeout, then FSM must be idle again.
    send(8'hE0);
    c_cyc = last_cap;
    expect_ev(c_cyc + 20, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    wait_to(c_cyc + 24);
    send(8'h1D);
    expect_ev(last_cap, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 1'b0);
    send(8'hF0); send(8'h1D);
    expect_ev(last_cap, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 1'b0);
    idle(2);

    // Malformed sequences: F0 E0 and E0 F0 F0.
    send(8'hF0); send(8'hE0);
    expect_ev(last_cap, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    send(8'hE0); send(8'hF0); send(8'hF0);
    expect_ev(last_cap, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    send(8'h1D);
    expect_ev(last_cap, 5'b00000 | 5'b00001, 5'b00000, 5'b00000, 5'b00001, 1'b0);
    send(8'hF0); send(8'h1D);
    expect_ev(last_cap, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 1'b0);

    idle(20);
    n_chk++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: %0d still queued, expected 0 (next due at cyc %0d)",
               expq.size(), expq[0].at);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
